// File: rtl/mem_pkg.sv
// Shared constants for the data-side memory responder.
// Access widths, MMIO register map and console status layout.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_width_e;

    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

    localparam logic [3:0] CONSOLE_DATA   = 4'h0;
    localparam logic [3:0] CONSOLE_STATUS = 4'h4;
    localparam logic [3:0] CYCLE          = 4'h8;
    localparam logic [3:0] EXIT           = 4'hC;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 3;
    localparam int ST_CNT_W  = 5;

    function automatic logic [31:0] extend(
        input logic [15:0] v,
        input logic        is_half,
        input logic        sext
    );
        logic [31:0] r;
        if (is_half)
            r = {{16{sext & v[15]}}, v};
        else
            r = {{24{sext & v[7]}}, v[7:0]};
        return r;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console transmit FIFO with wrap-bit pointers.
// A push while full succeeds only when a pop frees a slot the same cycle.
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_mem.sv
// Data-side memory: word RAM with byte lanes plus a small MMIO page.
// Loads are combinational; stores and register updates are clocked.
module data_mem
    import mem_pkg::*;
#(
    parameter int WORDS      = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwdata,
    input  logic        memw,
    input  logic        memsext,
    input  logic [1:0]  memwidth,
    output logic [31:0] memrdata,
    output logic        fault,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);

    localparam int IW = $clog2(WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(WORDS * 4);

    logic [31:0] ram [WORDS];
    logic [31:0] cycle_q;
    logic        ovf;

    logic        is_ram;
    logic        is_mmio;
    logic        bad_align;
    logic        ram_we;
    logic        mmio_we;
    logic [IW-1:0] idx;

    logic        sel_data;
    logic        sel_stat;
    logic        sel_cyc;
    logic        sel_exit;

    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic        push_req;
    logic        pop;

    logic [31:0] word;
    logic [31:0] shifted;
    logic [15:0] half_v;
    logic [31:0] ram_rd;
    logic [31:0] mmio_rd;
    logic [31:0] status;
    logic [3:0]  be;
    logic [31:0] wd;

    assign is_ram  = memaddr < RAM_BYTES;
    assign is_mmio = memaddr[31:4] == MMIO_BASE[31:4];
    assign idx     = memaddr[IW+1:2];

    always_comb begin
        bad_align = 1'b1;
        unique case (memwidth)
            MEM_B:   bad_align = 1'b0;
            MEM_H:   bad_align = memaddr[0];
            MEM_W:   bad_align = |memaddr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    // MMIO registers only accept full-word accesses
    assign fault = bad_align
                 | ~(is_ram | is_mmio)
                 | (is_mmio & (memwidth != MEM_W));

    assign ram_we  = memw & ~fault & is_ram;
    assign mmio_we = memw & ~fault & is_mmio;

    assign sel_data = memaddr[3:0] == CONSOLE_DATA;
    assign sel_stat = memaddr[3:0] == CONSOLE_STATUS;
    assign sel_cyc  = memaddr[3:0] == CYCLE;
    assign sel_exit = memaddr[3:0] == EXIT;

    assign push_req = mmio_we & sel_data;
    assign pop      = tx_valid & tx_ready;
    assign tx_valid = ~fifo_empty;

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (memwdata[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign word    = ram[idx];
    assign shifted = word >> {memaddr[1:0], 3'b000};
    assign half_v  = memaddr[1] ? word[31:16] : word[15:0];

    always_comb begin
        ram_rd = word;
        unique case (memwidth)
            MEM_B:   ram_rd = extend(shifted[15:0], 1'b0, memsext);
            MEM_H:   ram_rd = extend(half_v, 1'b1, memsext);
            default: ram_rd = word;
        endcase
    end

    always_comb begin
        status = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf;
        status[ST_CNT_LO +: ST_CNT_W] = ST_CNT_W'(fifo_cnt);
    end

    always_comb begin
        mmio_rd = '0;
        unique case (1'b1)
            sel_stat: mmio_rd = status;
            sel_cyc:  mmio_rd = cycle_q;
            sel_exit: mmio_rd = exit_code;
            default:  mmio_rd = '0;
        endcase
    end

    assign memrdata = fault  ? '0
                    : is_ram ? ram_rd
                    : mmio_rd;

    // Replicate store data so every lane already holds its bytes
    always_comb begin
        be = 4'b1111;
        wd = memwdata;
        unique case (memwidth)
            MEM_B: begin
                be = 4'b0001 << memaddr[1:0];
                wd = {4{memwdata[7:0]}};
            end
            MEM_H: begin
                be = memaddr[1] ? 4'b1100 : 4'b0011;
                wd = {2{memwdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = memwdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    ram[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            ovf       <= 1'b0;
            halt      <= 1'b0;
            exit_code <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (push_req && fifo_full && !pop)
                ovf <= 1'b1;
            if (mmio_we && sel_exit && !halt) begin
                halt      <= 1'b1;
                exit_code <= memwdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: driver queues expectations,
// a negedge monitor compares loads, halt state and console output.
module tb_data_mem;

    localparam logic [31:0] A_DATA = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
    localparam logic [31:0] A_EXIT = 32'hFFFF_000C;

    localparam int K_LD   = 0;
    localparam int K_HALT = 1;
    localparam int K_TXV  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] memaddr = '0;
    logic [31:0] memwdata = '0;
    logic        memw = 1'b0;
    logic        memsext = 1'b0;
    logic [1:0]  memwidth = 2'd2;
    logic [31:0] memrdata;
    logic        fault;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic [31:0] exit_code;

    int checks = 0;
    int errors = 0;

    string       nm_q[$];
    int          kd_q[$];
    logic [31:0] v_q[$];
    logic        f_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    data_mem #(
        .WORDS      (1024),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memaddr   (memaddr),
        .memwdata  (memwdata),
        .memw      (memw),
        .memsext   (memsext),
        .memwidth  (memwidth),
        .memrdata  (memrdata),
        .fault     (fault),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .exit_code (exit_code)
    );

    task automatic expect_e(input string n, input int k,
                            input logic [31:0] v, input logic f);
        nm_q.push_back(n);
        kd_q.push_back(k);
        v_q.push_back(v);
        f_q.push_back(f);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic s,
                         input logic [1:0] wid);
        @(posedge clk);
        #1;
        memaddr  = a;
        memwdata = d;
        memw     = w;
        memsext  = s;
        memwidth = wid;
    endtask

    task automatic ld(input string n, input logic [31:0] a,
                      input logic s, input logic [1:0] wid,
                      input logic [31:0] ev, input logic ef);
        drive(a, 32'h0, 1'b0, s, wid);
        expect_e(n, K_LD, ev, ef);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] wid);
        drive(a, d, 1'b1, 1'b0, wid);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd2);
    endtask

    always @(negedge clk) begin : mon
        string       n;
        int          k;
        logic [31:0] v;
        logic        f;
        logic [7:0]  e;
        while (kd_q.size() > 0) begin
            n = nm_q.pop_front();
            k = kd_q.pop_front();
            v = v_q.pop_front();
            f = f_q.pop_front();
            checks++;
            case (k)
                K_LD: if (memrdata !== v || fault !== f) begin
                    errors++;
                    $display("FAIL %s: rdata=%h fault=%b, want rdata=%h fault=%b",
                             n, memrdata, fault, v, f);
                end
                K_HALT: if (halt !== f || exit_code !== v) begin
                    errors++;
                    $display("FAIL %s: halt=%b code=%h, want halt=%b code=%h",
                             n, halt, exit_code, f, v);
                end
                default: if (tx_valid !== f) begin
                    errors++;
                    $display("FAIL %s: tx_valid=%b, want %b", n, tx_valid, f);
                end
            endcase
        end
        if (tx_valid && tx_ready) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_pop: got %h, want no pop", tx_data);
            end else begin
                e = tx_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_pop: got %h, want %h", tx_data, e);
                end
            end
        end
    end

    initial begin
        // reset state
        idle(1);
        expect_e("rst_halt", K_HALT, 32'h0, 1'b0);
        expect_e("rst_txv", K_TXV, 32'h0, 1'b0);
        idle(1);

        // release reset and read CYCLE in that same cycle
        @(posedge clk);
        #1;
        reset = 1'b0;
        memaddr = A_CYC;
        memw = 1'b0;
        memwidth = 2'd2;
        expect_e("cycle0", K_LD, 32'd0, 1'b0);
        idle(99);
        ld("cycle100", A_CYC, 1'b0, 2'd2, 32'd100, 1'b0);

        @(posedge clk);
        #1;
        force dut.cycle_q = 32'hFFFF_FFFF;
        memaddr = A_CYC;
        expect_e("cycle_forced", K_LD, 32'hFFFF_FFFF, 1'b0);
        #5;
        release dut.cycle_q;
        ld("cycle_wrap", A_CYC, 1'b0, 2'd2, 32'd0, 1'b0);

        // little-endian lanes
        st(32'h10, 32'h8081_7F01, 2'd2);
        ld("lb_11", 32'h11, 1'b1, 2'd0, 32'h0000_007F, 1'b0);
        ld("lb_13", 32'h13, 1'b1, 2'd0, 32'hFFFF_FF80, 1'b0);
        ld("lbu_13", 32'h13, 1'b0, 2'd0, 32'h0000_0080, 1'b0);
        ld("lh_12", 32'h12, 1'b1, 2'd1, 32'hFFFF_8081, 1'b0);
        ld("lhu_12", 32'h12, 1'b0, 2'd1, 32'h0000_8081, 1'b0);
        ld("lw_10", 32'h10, 1'b0, 2'd2, 32'h8081_7F01, 1'b0);

        // partial stores
        st(32'h20, 32'hAABB_CCDD, 2'd2);
        st(32'h22, 32'h0000_0011, 2'd0);
        ld("sb_merge", 32'h20, 1'b0, 2'd2, 32'hAA11_CCDD, 1'b0);
        st(32'h30, 32'h0, 2'd2);
        st(32'h32, 32'h1234_BEEF, 2'd1);
        ld("sh_merge", 32'h30, 1'b0, 2'd2, 32'hBEEF_0000, 1'b0);

        // load during store returns old data
        st(32'h40, 32'h1111_1111, 2'd2);
        drive(32'h40, 32'h2222_2222, 1'b1, 1'b0, 2'd2);
        expect_e("st_ld_old", K_LD, 32'h1111_1111, 1'b0);
        ld("st_ld_new", 32'h40, 1'b0, 2'd2, 32'h2222_2222, 1'b0);

        // faults
        ld("lh_misal", 32'h21, 1'b1, 2'd1, 32'h0, 1'b1);
        drive(32'h22, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd2);
        expect_e("sw_misal", K_LD, 32'h0, 1'b1);
        ld("sw_misal_kept", 32'h20, 1'b0, 2'd2, 32'hAA11_CCDD, 1'b0);
        ld("unmapped", 32'h4000_0000, 1'b0, 2'd2, 32'h0, 1'b1);
        ld("width3", 32'h20, 1'b0, 2'd3, 32'h0, 1'b1);
        ld("mmio_byte", A_STAT, 1'b0, 2'd0, 32'h0, 1'b1);
        ld("mmio_gap", 32'hFFFF_0010, 1'b0, 2'd2, 32'h0, 1'b1);
        st(32'hFFC, 32'hCAFE_F00D, 2'd2);
        ld("lw_top", 32'hFFC, 1'b0, 2'd2, 32'hCAFE_F00D, 1'b0);
        ld("lw_past_top", 32'h1000, 1'b0, 2'd2, 32'h0, 1'b1);

        // FIFO overflow with sink stalled
        st(A_DATA, 32'h41, 2'd2);
        st(A_DATA, 32'h42, 2'd2);
        st(A_DATA, 32'h43, 2'd2);
        st(A_DATA, 32'h44, 2'd2);
        st(A_DATA, 32'h45, 2'd2);
        ld("stat_full", A_STAT, 1'b0, 2'd2, 32'h25, 1'b0);
        ld("data_rd0", A_DATA, 1'b0, 2'd2, 32'h0, 1'b0);

        // push and pop together while full, then drain
        drive(A_DATA, 32'h46, 1'b1, 1'b0, 2'd2);
        tx_ready = 1'b1;
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h42);
        tx_q.push_back(8'h43);
        tx_q.push_back(8'h44);
        tx_q.push_back(8'h46);
        ld("stat_pushpop", A_STAT, 1'b0, 2'd2, 32'h25, 1'b0);
        idle(3);
        ld("stat_drained", A_STAT, 1'b0, 2'd2, 32'h06, 1'b0);
        expect_e("txv_drained", K_TXV, 32'h0, 1'b0);

        // push into empty FIFO: valid rises next cycle
        drive(A_DATA, 32'h47, 1'b1, 1'b0, 2'd2);
        expect_e("txv_pre", K_TXV, 32'h0, 1'b0);
        tx_q.push_back(8'h47);
        ld("stat_one", A_STAT, 1'b0, 2'd2, 32'h0C, 1'b0);
        expect_e("txv_post", K_TXV, 32'h0, 1'b1);
        idle(1);

        // EXIT
        drive(A_EXIT, 32'h2A, 1'b1, 1'b0, 2'd2);
        expect_e("halt_pre", K_HALT, 32'h0, 1'b0);
        ld("exit_rd", A_EXIT, 1'b0, 2'd2, 32'h2A, 1'b0);
        expect_e("halt_set", K_HALT, 32'h2A, 1'b1);
        drive(A_EXIT, 32'h7, 1'b1, 1'b0, 2'd2);
        ld("exit_kept", A_EXIT, 1'b0, 2'd2, 32'h2A, 1'b0);
        expect_e("halt_kept", K_HALT, 32'h2A, 1'b1);

        // reset in the middle of a drain
        tx_ready = 1'b0;
        st(A_DATA, 32'h48, 2'd2);
        st(A_DATA, 32'h49, 2'd2);
        st(A_DATA, 32'h4A, 2'd2);
        idle(1);
        tx_ready = 1'b1;
        tx_q.push_back(8'h48);
        @(posedge clk);
        #1;
        reset = 1'b1;
        memaddr = 32'h20;
        memw = 1'b0;
        memwidth = 2'd2;
        expect_e("rst_rd", K_LD, 32'hAA11_CCDD, 1'b0);
        expect_e("rst_halt2", K_HALT, 32'h0, 1'b0);
        expect_e("rst_txv2", K_TXV, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        memaddr = A_CYC;
        expect_e("cycle0_again", K_LD, 32'd0, 1'b0);
        ld("ram_kept", 32'h20, 1'b0, 2'd2, 32'hAA11_CCDD, 1'b0);
        ld("stat_reset", A_STAT, 1'b0, 2'd2, 32'h02, 1'b0);
        expect_e("txv_reset", K_TXV, 32'h0, 1'b0);
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (kd_q.size() != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: exp=%0d tx=%0d, want 0 and 0",
                     kd_q.size(), tx_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Data-side memory responder for the single-cycle hart: it serves the hart's `memaddr`/`memwdata`/`memw`/`memsext`/`memwidth`/`memrdata` port. It holds a word-organised RAM with little-endian byte/half/word access, sign or zero extension, and fault detection. A small MMIO page provides a buffered console transmitter, a cycle counter and a simulation exit register. Loads are combinational, because the hart completes in one cycle; stores, FIFO pushes and register updates are synchronous.

## Interface
- `WORDS`, 1024: RAM depth in 32-bit words; power of two. RAM spans byte addresses 0 to WORDS*4-1.
- `FIFO_DEPTH`, 4: console TX FIFO entries; power of two, 2 or more.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memaddr`  in  32  byte address.
- `memwdata`  in  32  store data; only lanes selected by width and address are used.
- `memw`  in  1  store strobe for this cycle.
- `memsext`  in  1  1 selects sign-extended loads, 0 selects zero-extended loads.
- `memwidth`  in  2  access width: 0 byte, 1 half, 2 word, 3 illegal.
- `memrdata`  out  32  load data, combinational.
- `fault`  out  1  combinational; asserted for a misaligned, illegal-width or unmapped access.
- `tx_data`  out  8  head of the console FIFO.
- `tx_valid`  out  1  FIFO is non-empty.
- `tx_ready`  in  1  console sink accepts `tx_data` when this and `tx_valid` are both high.
- `halt`  out  1  sticky; set by a write to EXIT.
- `exit_code`  out  32  value written to EXIT.

## Operation
- Address decode:
  - RAM: `memaddr < WORDS*4`.
  - MMIO: `memaddr[31:4] == 28'hFFFF000`.
  - Anything else is unmapped: `fault=1`, `memrdata=0`, stores ignored.
- Alignment:
  - Half access with `addr[0]=1` is a fault.
  - Word access with `addr[1:0]!=0` is a fault.
  - `memwidth=3` is always a fault.
  - On any fault, `memrdata=0` and the store is suppressed.
- RAM loads:
  - Word index is `addr[log2(WORDS)+1:2]`.
  - Byte access selects lane `addr[1:0]`; half access selects lane `addr[1]`.
  - The selected value is extended to 32 bits as chosen by `memsext`.
- RAM stores:
  - Byte-enable write to the lane(s) selected by width and address.
  - Unselected bytes are unchanged.
  - Data comes from the low bits of `memwdata`.
- MMIO registers (word access only; any other width is a fault):
  - +0x0 CONSOLE_DATA. Write pushes `memwdata[7:0]` into the FIFO. A push while full is dropped and sets sticky `ovf`. Reads return 0.
  - +0x4 CONSOLE_STATUS. Read only: bit0 full, bit1 empty, bit2 `ovf`, bits[7:3] occupancy count. All other bits are 0.
  - +0x8 CYCLE. Read only: free-running counter that increments every cycle and wraps at 2^32. Writes are ignored.
  - +0xC EXIT. Write sets `halt=1` and `exit_code=memwdata`. Later EXIT writes are ignored while halted. Reads return `exit_code`.
- FIFO:
  - `tx_data` always shows the head entry.
  - A pop occurs when `tx_valid && tx_ready`.
  - Push and pop in the same cycle:
    - When full: both happen, and the count is unchanged with no `ovf`.
    - When empty: the push happens, no pop occurs, and `tx_valid` rises the next cycle.
- Reset:
  - FIFO is emptied, `ovf=0`, CYCLE=0, `halt=0`, `exit_code=0`.
  - RAM contents are not reset and are retained across reset.
  - Reset may be asserted in any cycle; a store coincident with reset is lost for MMIO and undefined for RAM.

## Timing
- Loads have zero latency: `memrdata` and `fault` follow the address, width and sext inputs combinationally.
- Stores commit at the rising edge while `memw=1`.
- A load in the same cycle as a store to that address returns the old data. Loads see new data from the next cycle.
- CYCLE reads return the current, pre-increment value; the first cycle after reset release reads 0.
- `tx_valid` goes high the cycle after a push into an empty FIFO. It drops the cycle after the last pop.
- `halt` and `exit_code` change the cycle after the EXIT write.
- Output values during reset: `memrdata` follows the combinational decode; `tx_valid=0`, `tx_data=0`, `halt=0`, `exit_code=0`.

## Structure
- Package `mem_pkg`:
  - width enum `MEM_B=0`, `MEM_H=1`, `MEM_W=2`.
  - `MMIO_BASE=32'hFFFF_0000`.
  - register offsets `CONSOLE_DATA`, `CONSOLE_STATUS`, `CYCLE`, `EXIT`.
  - status bit positions.
- Sub-module `tx_fifo`:
  - Parameterised width and depth; async active-high reset.
  - Push/pop/full/empty/count.
  - Circular pointers with one extra wrap bit.
- Everything else lives in `data_mem`: decode, lane steering, extension, CYCLE and EXIT registers.

## Test plan
- Little-endian lanes: SW `0x8081_7F01` to addr 0x10, then:
  - LB 0x11 sext → `0x0000_007F`
  - LB 0x13 sext → `0xFFFF_FF80`
  - LBU 0x13 → `0x0000_0080`
  - LH 0x12 sext → `0xFFFF_8081`
- Partial store: SW `0xAABB_CCDD` to 0x20, then SB `0x11` to 0x22 → LW 0x20 = `0xAA11_CCDD`.
- Faults:
  - LH 0x21 → `fault=1`, `memrdata=0`.
  - SW to 0x22 → RAM unchanged.
  - LW `0x4000_0000` (unmapped) → `fault=1`.
  - `memwidth=3` → `fault=1`.
- FIFO:
  - Hold `tx_ready=0`, write 'A','B','C','D','E' → STATUS full=1, `ovf=1`, count=4.
  - Raise `tx_ready` → drains A,B,C,D in order; E is lost.
  - Push and pop in one cycle while full → count stays 4, `ovf` unchanged.
- CYCLE: release reset, read at cycle 0 → 0; read at cycle 100 → 100; preload to `0xFFFF_FFFF` via force → next read 0.
- EXIT/reset:
  - Write `0x2A` to EXIT → next cycle `halt=1`, `exit_code=0x2A`; a later write of 7 is ignored.
  - Assert reset mid-FIFO-drain → `halt=0`, `tx_valid=0`, CYCLE=0, RAM word at 0x20 still `0xAA11_CCDD`.
